// File: rtl/dtmf_dial_sequencer.sv
// DTMF dial sequencer: an Avalon-MM slave with a digit FIFO. Each queued digit is
// played as a timed tone burst on dtmf_select/tone_on, followed by an inter-digit gap.
module dtmf_dial_sequencer #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DEF_TON    = 100,
  parameter int unsigned DEF_TOFF   = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  dtmf_select,
  output logic        tone_on,
  output logic        busy,
  output logic        irq
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [4:0]       CNT_FULL = 5'(FIFO_DEPTH);
  localparam logic [15:0]      TON_RST  = 16'(DEF_TON);
  localparam logic [15:0]      TOFF_RST = 16'(DEF_TOFF);

  typedef enum logic [1:0] { S_IDLE, S_TONE, S_GAP } state_t;

  state_t           state_q, state_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             enable_q, enable_d, irq_en_q, irq_en_d;
  logic             overflow_q, overflow_d, done_pend_q, done_pend_d;
  logic [15:0]      ton_q, ton_d, toff_q, toff_d;
  logic [15:0]      dur_q, dur_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       select_q, select_d;
  logic             tone_q, tone_d;

  logic        wr_en, push_req, ctrl_wr, flush, push_ok, pop, set_done;
  logic        fifo_empty, fifo_full, tick_wrap, phase_done;
  logic [15:0] ton_eff, toff_eff;
  logic        unused_wdata;

  assign wr_en      = chipselect & ~write_n;
  assign push_req   = wr_en && (address == 2'd0);
  assign ctrl_wr    = wr_en && (address == 2'd3);
  assign flush      = ctrl_wr && writedata[1];
  assign fifo_empty = (count_q == 5'd0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign push_ok    = push_req && !flush && !fifo_full;
  assign tick_wrap  = (pre_q == PRE_LAST);
  assign phase_done = tick_wrap && (dur_q == 16'd1);
  assign ton_eff    = (ton_q == 16'd0) ? 16'd1 : ton_q;
  assign toff_eff   = (toff_q == 16'd0) ? 16'd1 : toff_q;
  assign unused_wdata = ^writedata[31:16];

  // A flush aborts whatever phase is running; otherwise the FSM walks TONE/GAP per digit.
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    dur_d    = dur_q;
    select_d = select_q;
    tone_d   = tone_q;
    pop      = 1'b0;
    set_done = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      tone_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_q && !fifo_empty) begin
            pop      = 1'b1;
            select_d = mem_q[rd_ptr_q];
            tone_d   = 1'b1;
            dur_d    = ton_eff;
            pre_d    = '0;
            state_d  = S_TONE;
          end
        end
        S_TONE: begin
          if (phase_done) begin
            tone_d  = 1'b0;
            dur_d   = toff_eff;
            pre_d   = '0;
            state_d = S_GAP;
          end else if (tick_wrap) begin
            pre_d = '0;
            dur_d = dur_q - 16'd1;
          end else begin
            pre_d = pre_q + PRE_ONE;
          end
        end
        S_GAP: begin
          if (phase_done) begin
            if (enable_q && !fifo_empty) begin
              pop      = 1'b1;
              select_d = mem_q[rd_ptr_q];
              tone_d   = 1'b1;
              dur_d    = ton_eff;
              pre_d    = '0;
              state_d  = S_TONE;
            end else begin
              state_d  = S_IDLE;
              set_done = fifo_empty;
            end
          end else if (tick_wrap) begin
            pre_d = '0;
            dur_d = dur_q - 16'd1;
          end else begin
            pre_d = pre_q + PRE_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    overflow_d  = overflow_q;
    done_pend_d = done_pend_q;
    ton_d       = ton_q;
    toff_d      = toff_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 5'd0;
    end else begin
      if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      if (push_ok && !pop)      count_d = count_q + 5'd1;
      else if (!push_ok && pop) count_d = count_q - 5'd1;
    end
    if (ctrl_wr) begin
      enable_d = writedata[0];
      irq_en_d = writedata[2];
      if (writedata[8]) begin
        overflow_d  = 1'b0;
        done_pend_d = 1'b0;
      end
    end
    // A completion on the same edge as a clear leaves done_pend set.
    if (push_req && !flush && fifo_full) overflow_d = 1'b1;
    if (set_done) done_pend_d = 1'b1;
    if (wr_en && (address == 2'd1)) ton_d  = writedata[15:0];
    if (wr_en && (address == 2'd2)) toff_d = writedata[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 5'd0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      overflow_q  <= 1'b0;
      done_pend_q <= 1'b0;
      ton_q       <= TON_RST;
      toff_q      <= TOFF_RST;
      dur_q       <= 16'd0;
      pre_q       <= '0;
      select_q    <= 4'd0;
      tone_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      overflow_q  <= overflow_d;
      done_pend_q <= done_pend_d;
      ton_q       <= ton_d;
      toff_q      <= toff_d;
      dur_q       <= dur_d;
      pre_q       <= pre_d;
      select_q    <= select_d;
      tone_q      <= tone_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= writedata[3:0];
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: begin
        readdata[4:0] = count_q;
        readdata[8]   = fifo_empty;
        readdata[9]   = fifo_full;
        readdata[10]  = busy;
        readdata[11]  = overflow_q;
        readdata[12]  = done_pend_q;
      end
      2'd1: readdata[15:0] = ton_q;
      2'd2: readdata[15:0] = toff_q;
      default: begin
        readdata[0]  = enable_q;
        readdata[2]  = irq_en_q;
        readdata[12] = done_pend_q;
      end
    endcase
  end

  assign dtmf_select = select_q;
  assign tone_on     = tone_q;
  assign busy        = (state_q != S_IDLE);
  assign irq         = done_pend_q & irq_en_q;

endmodule

// File: doc/dtmf_dial_sequencer.md
# dtmf_dial_sequencer

- Avalon-MM slave that plays DTMF digit strings.
- Software writes digit codes into an internal FIFO and programs tone-on and inter-digit gap durations.
- The block then drives the 4-bit DTMF select bus and a tone enable autonomously, one digit at a time.
- It sits between the Nios II data master and the DTMF tone generator, so CPU-side PIO toggling of the select lines is no longer needed.

## Interface
Parameters:
- TICK_DIV, 50000: clk cycles per duration tick (1 ms at 50 MHz); must be ≥ 1.
- FIFO_DEPTH, 16: digit FIFO entries; must be a power of 2, at most 16.
- DEF_TON, 100: reset value of the tone-on register, in ticks.
- DEF_TOFF, 100: reset value of the gap register, in ticks.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states.
- dtmf_select  out  4  current digit code to the tone generator.
- tone_on  out  1  tone generator enable.
- busy  out  1  high whenever the FSM is not IDLE.
- irq  out  1  level interrupt: done_pend AND irq_en.

## Operation
Register map. A write occurs when chipselect=1, write_n=0 and address selects the register.
- 0 DIGIT/STATUS
  - Write pushes writedata[3:0] into the FIFO.
  - Read returns: [4:0] fifo count, [8] empty, [9] full, [10] busy, [11] overflow (sticky), [12] done_pend.
- 1 TON: [15:0] tone-on ticks. Read returns the value zero-extended.
- 2 TOFF: [15:0] gap ticks. Read returns the value zero-extended.
- 3 CONTROL
  - Write bit [0] enable and bit [2] irq_en (both stored).
  - Write [1]=1 flushes; this bit is not stored.
  - Write [8]=1 clears overflow and done_pend.
  - Read returns {done_pend at [12], irq_en at [2], enable at [0]}; all other bits 0.

FIFO:
- A push when full is dropped and sets overflow.
- A push and a pop on the same edge are both performed; count is unchanged.
- A flush write empties the FIFO. In the same edge the FSM aborts to IDLE and tone_on goes to 0.
- If a flush and a FIFO push land on the same edge, the flush wins.

FSM states: IDLE, TONE, GAP.
- IDLE: if enable=1 and the FIFO is not empty:
  - pop the head entry into dtmf_select;
  - set tone_on=1;
  - load the duration counter with max(TON,1);
  - restart the prescaler;
  - go to TONE.
- TONE: the prescaler counts 0..TICK_DIV-1; each wrap decrements the duration counter. When the counter reaches 0:
  - set tone_on=0;
  - load max(TOFF,1) and restart the prescaler;
  - go to GAP.
- GAP: on duration-counter expiry:
  - if enable=1 and the FIFO is not empty, pop the next digit and enter TONE (same actions as from IDLE);
  - otherwise go to IDLE, and set done_pend=1 if the FIFO is empty.
- Clearing enable while in TONE or GAP completes the current digit and its gap, then goes to IDLE. done_pend is not set in this case if the FIFO is still non-empty.
- TON and TOFF are sampled only when a phase is entered. Writes made during a phase take effect at the next phase.
- dtmf_select holds the last digit played after tone_on falls.

Reset values:
- dtmf_select=0, tone_on=0, busy=0, irq=0.
- FIFO empty, enable=0, irq_en=0, overflow=0, done_pend=0.
- TON=DEF_TON, TOFF=DEF_TOFF, FSM=IDLE.

## Timing
- Let the write edge be k: a DIGIT push into an empty FIFO, with enable=1 and the FSM in IDLE. The FIFO count is visible at edge k. dtmf_select and tone_on update at edge k+1.
- tone_on stays high for exactly max(TON,1)×TICK_DIV cycles.
- The gap lasts exactly max(TOFF,1)×TICK_DIV cycles.
- The next digit's tone_on rises on the same edge that ends the gap. There is no extra idle cycle.
- done_pend, and irq if irq_en=1, assert on the edge the FSM enters IDLE at the end of the last gap.
- Asynchronous reset mid-tone forces tone_on=0 immediately and discards the FIFO contents.

## Test plan
- TICK_DIV=4, TON=2, TOFF=3, enable=1, push 5 -> dtmf_select=5 at edge k+1. tone_on high for 8 cycles, low for 12 cycles. busy falls after the gap and done_pend=1.
- Push digits 1,2,3 back-to-back, then enable -> tone pulses for 1, 2, 3 in order with exact gaps between them. STATUS count steps 3→2→1→0.
- Push 17 digits with enable=0 (depth 16) -> count=16, full=1, overflow=1. Write CONTROL[8]=1 -> overflow=0.
- TON=0, TOFF=0 -> each phase lasts exactly TICK_DIV cycles.
- Flush during TONE of the second of three digits -> tone_on=0 on the next edge, FSM in IDLE, count=0, done_pend unchanged.
- irq_en=1, play one digit -> irq rises when IDLE is entered. Write CONTROL[8]=1 -> irq=0. Assert reset_n=0 mid-tone -> all outputs return to reset values.
